// File: rtl/core_pkg.sv
// Shared fetch-path types and constants used by the instruction-fetch controller.
package core_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOCAL = 2'd1,
      EXT   = 2'd2,
      RESP  = 2'd3
   } fetchState_e;

   localparam logic [31:0] NOP_INST          = 32'h0000_0013;
   localparam logic [31:0] DEFAULT_IMEM_BASE = 32'h0000_0000;

   function automatic logic isAligned(input logic [31:0] addr);
      return (addr[1:0] == 2'b00);
   endfunction

endpackage

// File: rtl/ifetch_ctrl_if.sv
// Bus bundle between core fetch stage, local imem and external instruction port.
interface ifetch_ctrl_if #(
   parameter int IMEM_AW = 8
);
   logic               fetch_req;
   logic [31:0]        fetch_addr;
   logic               flush;
   logic               fetch_rdy;
   logic [31:0]        fetch_inst;
   logic               fetch_err;
   logic               busy;
   logic               imem_ren;
   logic [IMEM_AW-1:0] imem_addr;
   logic [31:0]        imem_rdata;
   logic               exIns_ren;
   logic [31:0]        exIns_addr;
   logic               exIns_valid;
   logic [31:0]        exIns_in;

   // Controller side of the bundle.
   modport slave (
      input  fetch_req, fetch_addr, flush, imem_rdata, exIns_valid, exIns_in,
      output fetch_rdy, fetch_inst, fetch_err, busy, imem_ren, imem_addr,
             exIns_ren, exIns_addr
   );

   // Environment side: core, imem and external port.
   modport master (
      output fetch_req, fetch_addr, flush, imem_rdata, exIns_valid, exIns_in,
      input  fetch_rdy, fetch_inst, fetch_err, busy, imem_ren, imem_addr,
             exIns_ren, exIns_addr
   );
endinterface

// File: rtl/ifetch_timeout.sv
// Saturating wait counter for the external port; expire marks the last allowed cycle.
module ifetch_timeout #(
   parameter int TIMEOUT = 15
) (
   input  logic clk,
   input  logic nrst,
   input  logic clr,
   input  logic inc,
   output logic expire
);
   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);
   localparam logic [CW-1:0] MAX  = CW'(TIMEOUT);

   logic [CW-1:0] cnt_r;

   // Count cycles spent waiting; clear on leaving or entering the wait.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         cnt_r <= {CW{1'b0}};
      end else if (clr) begin
         cnt_r <= {CW{1'b0}};
      end else if (inc && (cnt_r != MAX)) begin
         cnt_r <= cnt_r + CW'(1);
      end else begin
         cnt_r <= cnt_r;
      end
   end

   assign expire = (cnt_r >= LAST);
endmodule

// File: rtl/ifetch_ctrl.sv
// Instruction-fetch controller: routes each fetch to local imem or the external port.
module ifetch_ctrl
   import core_pkg::*;
#(
   parameter logic [31:0] IMEM_BASE  = DEFAULT_IMEM_BASE,
   parameter int          IMEM_WORDS = 256,
   parameter int          TIMEOUT    = 15
) (
   input  logic         clk,
   input  logic         nrst,
   ifetch_ctrl_if.slave bus
);
   localparam int AW = $clog2(IMEM_WORDS);
   // 33-bit window bounds so a region ending at 4 GiB does not wrap.
   localparam logic [32:0] BASE33  = {1'b0, IMEM_BASE};
   localparam logic [32:0] LIMIT33 = BASE33 + (33'(IMEM_WORDS) << 2);

   fetchState_e   state_r, nextState_s;
   logic [31:0]   data_r, extAddr_r;
   logic          err_r;
   logic          busy_s, accept_s, aligned_s, isLocal_s, expire_s, cntClr_s;
   logic          rdy_s, err_s, imemRen_s;
   logic [31:0]   inst_s;
   logic [AW-1:0] imemIdx_s, imemAddr_s;

   assign aligned_s = isAligned(bus.fetch_addr);
   assign isLocal_s = ({1'b0, bus.fetch_addr} >= BASE33) && ({1'b0, bus.fetch_addr} < LIMIT33);
   assign imemIdx_s = AW'((bus.fetch_addr - IMEM_BASE) >> 2);
   assign busy_s    = (state_r == EXT) || (state_r == RESP);
   assign accept_s  = bus.fetch_req && !busy_s && !bus.flush;
   assign cntClr_s  = (state_r != EXT) || (nextState_s != EXT);

   ifetch_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
      .clk    (clk),
      .nrst   (nrst),
      .clr    (cntClr_s),
      .inc    (1'b1),
      .expire (expire_s)
   );

   // Next-state decode plus the combinational response and imem request.
   always_comb begin
      nextState_s = state_r;
      rdy_s       = 1'b0;
      inst_s      = 32'h0000_0000;
      err_s       = 1'b0;
      imemRen_s   = 1'b0;
      imemAddr_s  = {AW{1'b0}};
      case (state_r)
         IDLE, LOCAL: begin
            if ((state_r == LOCAL) && !bus.flush) begin
               rdy_s  = 1'b1;
               inst_s = bus.imem_rdata;
            end else begin
               rdy_s  = 1'b0;
            end
            if (accept_s) begin
               if (!aligned_s) begin
                  nextState_s = RESP;
               end else if (isLocal_s) begin
                  nextState_s = LOCAL;
                  imemRen_s   = 1'b1;
                  imemAddr_s  = imemIdx_s;
               end else begin
                  nextState_s = EXT;
               end
            end else begin
               nextState_s = IDLE;
            end
         end
         EXT: begin
            if (bus.flush) begin
               nextState_s = IDLE;
            end else if (bus.exIns_valid || expire_s) begin
               nextState_s = RESP;
            end else begin
               nextState_s = EXT;
            end
         end
         RESP: begin
            rdy_s       = !bus.flush;
            inst_s      = data_r;
            err_s       = err_r && !bus.flush;
            nextState_s = IDLE;
         end
         default: begin
            nextState_s = IDLE;
         end
      endcase
   end

   // State, captured response and latched external address.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_r   <= IDLE;
         data_r    <= 32'h0000_0000;
         err_r     <= 1'b0;
         extAddr_r <= 32'h0000_0000;
      end else begin
         state_r <= nextState_s;
         // Valid beats expiry when both land in the same cycle.
         if ((state_r == EXT) && bus.exIns_valid) begin
            data_r <= bus.exIns_in;
            err_r  <= 1'b0;
         end else if ((state_r == EXT) && expire_s) begin
            data_r <= NOP_INST;
            err_r  <= 1'b1;
         end else if (accept_s && !aligned_s) begin
            data_r <= NOP_INST;
            err_r  <= 1'b1;
         end else begin
            data_r <= data_r;
            err_r  <= err_r;
         end
         if (accept_s && aligned_s && !isLocal_s) begin
            extAddr_r <= bus.fetch_addr;
         end else begin
            extAddr_r <= extAddr_r;
         end
      end
   end

   assign bus.fetch_rdy  = rdy_s;
   assign bus.fetch_inst = inst_s;
   assign bus.fetch_err  = err_s;
   assign bus.busy       = busy_s;
   assign bus.imem_ren   = imemRen_s;
   assign bus.imem_addr  = imemAddr_s;
   assign bus.exIns_ren  = (state_r == EXT);
   assign bus.exIns_addr = extAddr_r;
endmodule

// File: tb/tb_ifetch_ctrl.sv
// Directed bench for ifetch_ctrl: local stream, external hit/timeout, misalign, flush, async reset.
module tb_ifetch_ctrl;
   logic clk;
   logic nrst;
   int   total;
   int   passed;

   localparam logic [31:0] NOP = 32'h0000_0013;

   ifetch_ctrl_if #(.IMEM_AW(8)) bus ();

   ifetch_ctrl #(
      .IMEM_BASE  (32'h0000_0000),
      .IMEM_WORDS (256),
      .TIMEOUT    (15)
   ) dut (
      .clk  (clk),
      .nrst (nrst),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // imem model: word i holds 0xC0DE_0000 | i, one-cycle read latency.
   always @(posedge clk) begin
      if (bus.imem_ren) bus.imem_rdata <= 32'hC0DE_0000 | {24'h000000, bus.imem_addr};
   end

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached, passed %0d of %0d", passed, total);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   initial begin
      total = 0;
      passed = 0;
      nrst = 1'b0;
      bus.fetch_req = 1'b0;
      bus.fetch_addr = 32'h0;
      bus.flush = 1'b0;
      bus.exIns_valid = 1'b0;
      bus.exIns_in = 32'h0;
      bus.imem_rdata = 32'h0;
      #2;
      chk("rst_rdy", {31'h0, bus.fetch_rdy}, 32'h0);
      chk("rst_err", {31'h0, bus.fetch_err}, 32'h0);
      chk("rst_inst", bus.fetch_inst, 32'h0);
      chk("rst_busy", {31'h0, bus.busy}, 32'h0);
      chk("rst_imem_ren", {31'h0, bus.imem_ren}, 32'h0);
      chk("rst_ex_ren", {31'h0, bus.exIns_ren}, 32'h0);
      chk("rst_ex_addr", bus.exIns_addr, 32'h0);
      #10 nrst = 1'b1;

      // Local stream 0x00, 0x04, 0x08
      cyc(); bus.fetch_req = 1'b1; bus.fetch_addr = 32'h0000_0000;
      mid(); chk("ls0_ren", {31'h0, bus.imem_ren}, 32'h1);
      chk("ls0_addr", {24'h0, bus.imem_addr}, 32'h0);
      chk("ls0_rdy", {31'h0, bus.fetch_rdy}, 32'h0);
      cyc(); bus.fetch_addr = 32'h0000_0004;
      mid(); chk("ls1_rdy", {31'h0, bus.fetch_rdy}, 32'h1);
      chk("ls1_inst", bus.fetch_inst, 32'hC0DE_0000);
      chk("ls1_addr", {24'h0, bus.imem_addr}, 32'h1);
      chk("ls1_busy", {31'h0, bus.busy}, 32'h0);
      cyc(); bus.fetch_addr = 32'h0000_0008;
      mid(); chk("ls2_rdy", {31'h0, bus.fetch_rdy}, 32'h1);
      chk("ls2_inst", bus.fetch_inst, 32'hC0DE_0001);
      chk("ls2_addr", {24'h0, bus.imem_addr}, 32'h2);
      cyc(); bus.fetch_req = 1'b0;
      mid(); chk("ls3_rdy", {31'h0, bus.fetch_rdy}, 32'h1);
      chk("ls3_inst", bus.fetch_inst, 32'hC0DE_0002);
      chk("ls3_err", {31'h0, bus.fetch_err}, 32'h0);
      chk("ls3_ren", {31'h0, bus.imem_ren}, 32'h0);
      cyc();
      mid(); chk("ls4_rdy", {31'h0, bus.fetch_rdy}, 32'h0);

      // External hit: request at N, valid at N+3, rdy at N+4
      cyc(); bus.fetch_req = 1'b1; bus.fetch_addr = 32'h0000_0400;
      mid(); chk("eh0_imem_ren", {31'h0, bus.imem_ren}, 32'h0);
      chk("eh0_ex_ren", {31'h0, bus.exIns_ren}, 32'h0);
      cyc(); bus.fetch_req = 1'b0;
      mid(); chk("eh1_ex_ren", {31'h0, bus.exIns_ren}, 32'h1);
      chk("eh1_ex_addr", bus.exIns_addr, 32'h0000_0400);
      chk("eh1_busy", {31'h0, bus.busy}, 32'h1);
      cyc();
      mid(); chk("eh2_ex_ren", {31'h0, bus.exIns_ren}, 32'h1);
      cyc(); bus.exIns_valid = 1'b1; bus.exIns_in = 32'h00A0_0093;
      mid(); chk("eh3_rdy", {31'h0, bus.fetch_rdy}, 32'h0);
      chk("eh3_ex_addr", bus.exIns_addr, 32'h0000_0400);
      cyc(); bus.exIns_valid = 1'b0; bus.exIns_in = 32'h0;
      mid(); chk("eh4_rdy", {31'h0, bus.fetch_rdy}, 32'h1);
      chk("eh4_inst", bus.fetch_inst, 32'h00A0_0093);
      chk("eh4_err", {31'h0, bus.fetch_err}, 32'h0);
      chk("eh4_ex_ren", {31'h0, bus.exIns_ren}, 32'h0);
      chk("eh4_busy", {31'h0, bus.busy}, 32'h1);
      cyc();
      mid(); chk("eh5_busy", {31'h0, bus.busy}, 32'h0);
      chk("eh5_rdy", {31'h0, bus.fetch_rdy}, 32'h0);

      // Timeout: ren high N+1..N+15, error response at N+16
      cyc(); bus.fetch_req = 1'b1; bus.fetch_addr = 32'h0000_0800;
      cyc(); bus.fetch_req = 1'b0;
      for (int i = 0; i < 15; i++) begin
         mid(); chk($sformatf("to_ren%0d", i), {31'h0, bus.exIns_ren}, 32'h1);
         chk($sformatf("to_rdy%0d", i), {31'h0, bus.fetch_rdy}, 32'h0);
         cyc();
      end
      mid(); chk("to_ren_end", {31'h0, bus.exIns_ren}, 32'h0);
      chk("to_rdy", {31'h0, bus.fetch_rdy}, 32'h1);
      chk("to_err", {31'h0, bus.fetch_err}, 32'h1);
      chk("to_inst", bus.fetch_inst, NOP);
      cyc();

      // Valid in the final timeout cycle wins
      cyc(); bus.fetch_req = 1'b1; bus.fetch_addr = 32'h0000_0C00;
      cyc(); bus.fetch_req = 1'b0;
      for (int i = 0; i < 14; i++) cyc();
      bus.exIns_valid = 1'b1; bus.exIns_in = 32'h1234_5678;
      mid(); chk("tv_ren", {31'h0, bus.exIns_ren}, 32'h1);
      cyc(); bus.exIns_valid = 1'b0;
      mid(); chk("tv_rdy", {31'h0, bus.fetch_rdy}, 32'h1);
      chk("tv_err", {31'h0, bus.fetch_err}, 32'h0);
      chk("tv_inst", bus.fetch_inst, 32'h1234_5678);
      cyc();

      // Misaligned
      cyc(); bus.fetch_req = 1'b1; bus.fetch_addr = 32'h0000_0006;
      mid(); chk("ma_imem_ren", {31'h0, bus.imem_ren}, 32'h0);
      cyc(); bus.fetch_req = 1'b0;
      mid(); chk("ma_ex_ren", {31'h0, bus.exIns_ren}, 32'h0);
      chk("ma_rdy", {31'h0, bus.fetch_rdy}, 32'h1);
      chk("ma_err", {31'h0, bus.fetch_err}, 32'h1);
      chk("ma_inst", bus.fetch_inst, NOP);
      cyc();
      mid(); chk("ma_rdy_end", {31'h0, bus.fetch_rdy}, 32'h0);

      // Flush in second EXT cycle, late valid ignored, then local 0x10
      cyc(); bus.fetch_req = 1'b1; bus.fetch_addr = 32'h0000_0400;
      cyc(); bus.fetch_req = 1'b0;
      cyc(); bus.flush = 1'b1;
      mid(); chk("fl_ren", {31'h0, bus.exIns_ren}, 32'h1);
      chk("fl_rdy", {31'h0, bus.fetch_rdy}, 32'h0);
      cyc(); bus.flush = 1'b0; bus.exIns_valid = 1'b1; bus.exIns_in = 32'hDEAD_BEEF;
      mid(); chk("fl_ren_drop", {31'h0, bus.exIns_ren}, 32'h0);
      chk("fl_busy", {31'h0, bus.busy}, 32'h0);
      chk("fl_rdy_late", {31'h0, bus.fetch_rdy}, 32'h0);
      cyc(); bus.exIns_valid = 1'b0; bus.fetch_req = 1'b1; bus.fetch_addr = 32'h0000_0010;
      mid(); chk("fl_loc_ren", {31'h0, bus.imem_ren}, 32'h1);
      chk("fl_loc_addr", {24'h0, bus.imem_addr}, 32'h4);
      cyc(); bus.fetch_req = 1'b0;
      mid(); chk("fl_loc_rdy", {31'h0, bus.fetch_rdy}, 32'h1);
      chk("fl_loc_inst", bus.fetch_inst, 32'hC0DE_0004);
      // Request together with flush is not accepted
      cyc(); bus.fetch_req = 1'b1; bus.fetch_addr = 32'h0000_0000; bus.flush = 1'b1;
      mid(); chk("fr_imem_ren", {31'h0, bus.imem_ren}, 32'h0);
      cyc(); bus.fetch_req = 1'b0; bus.flush = 1'b0;
      mid(); chk("fr_rdy", {31'h0, bus.fetch_rdy}, 32'h0);

      // Async reset mid-EXT
      cyc(); bus.fetch_req = 1'b1; bus.fetch_addr = 32'h0000_0400;
      cyc(); bus.fetch_req = 1'b0;
      cyc();
      mid(); chk("ar_pre_ren", {31'h0, bus.exIns_ren}, 32'h1);
      #2 nrst = 1'b0;
      #1;
      chk("ar_ren", {31'h0, bus.exIns_ren}, 32'h0);
      chk("ar_busy", {31'h0, bus.busy}, 32'h0);
      chk("ar_rdy", {31'h0, bus.fetch_rdy}, 32'h0);
      chk("ar_ex_addr", bus.exIns_addr, 32'h0);
      mid(); nrst = 1'b1;
      cyc(); bus.fetch_req = 1'b1; bus.fetch_addr = 32'h0000_0000;
      mid(); chk("ar_loc_ren", {31'h0, bus.imem_ren}, 32'h1);
      cyc(); bus.fetch_req = 1'b0;
      mid(); chk("ar_loc_rdy", {31'h0, bus.fetch_rdy}, 32'h1);
      chk("ar_loc_inst", bus.fetch_inst, 32'hC0DE_0000);
      cyc();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
